// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the multi-slave APB bridge.
//   apb_state_e : bridge FSM states
//   apb_req_t   : request record (default 32-bit configuration)
//   apb_rsp_t   : response record (default 32-bit configuration)
// The bridge re-declares width-parameterised copies of the records internally,
// so that non-default ADDR_W/DATA_W builds stay consistent.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: combinational request-address decoder.
//   i_addr : byte address of the incoming request
//   o_idx  : slave index, i_addr[SLV_AW +: SEL_W]
//   o_hit  : 1 when every address bit above the slave-index field is zero
module apb_addr_decode #(
    parameter int ADDR_W = 32,
    parameter int NSLV   = 4,
    parameter int SLV_AW = 8
) (
    input  logic [ADDR_W-1:0]       i_addr,
    output logic [$clog2(NSLV)-1:0] o_idx,
    output logic                    o_hit
);

    localparam int SEL_W = $clog2(NSLV);
    localparam int TOP   = SLV_AW + SEL_W;

    assign o_idx = i_addr[SLV_AW +: SEL_W];

    generate
        if (ADDR_W > TOP) begin : g_upper
            assign o_hit = ~|i_addr[ADDR_W-1:TOP];
        end else begin : g_no_upper
            assign o_hit = 1'b1;
        end
    endgenerate

    // Offset bits inside a slave region do not take part in the decode.
    logic w_unused_offset;
    assign w_unused_offset = ^i_addr[SLV_AW-1:0];

endmodule

// File: rtl/apb_multi_bridge.sv
// apb_multi_bridge: request/response master port to an APB4 bus with NSLV slaves.
//   clk, rst                         : clock, async active-high reset
//   req_valid/ready, req_wr/addr/
//   req_wdata/strb                   : request handshake and payload
//   rsp_valid, rsp_rdata, rsp_err    : registered one-cycle response
//   paddr, psel, penable, pwrite,
//   pwdata, pstrb                    : APB master outputs (psel one-hot)
//   prdata, pready, pslverr          : per-slave APB returns, slave i at index i
module apb_multi_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SLV_AW  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_strb,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      paddr,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [DATA_W-1:0]      pwdata,
    output logic [DATA_W/8-1:0]    pstrb,
    input  logic [NSLV*DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = $clog2(NSLV);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    apb_state_e r_state, w_next;
    req_t       r_req;
    logic [SEL_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic       r_rsp_valid;
    rsp_t       r_rsp;

    logic [SEL_W-1:0] w_dec_idx;
    logic             w_dec_hit;
    logic             w_sel_act;
    logic             w_acc;
    logic             w_in_access;
    logic             w_done;
    logic             w_tmo;
    logic             w_sel_ready;
    logic             w_sel_err;
    logic [DATA_W-1:0] w_sel_rdata;
    logic [NSLV-1:0][DATA_W-1:0] w_prdata_arr;

    apb_addr_decode #(
        .ADDR_W (ADDR_W),
        .NSLV   (NSLV),
        .SLV_AW (SLV_AW)
    ) u_dec (
        .i_addr (req_addr),
        .o_idx  (w_dec_idx),
        .o_hit  (w_dec_hit)
    );

    // Only the addressed slave's returns are ever looked at.
    assign w_prdata_arr = prdata;
    assign w_sel_ready  = pready[r_idx];
    assign w_sel_err    = pslverr[r_idx];
    assign w_sel_rdata  = w_prdata_arr[r_idx];

    assign w_in_access = (r_state == ACCESS);
    assign w_done      = w_in_access && w_sel_ready;
    // r_cnt holds the stalled ACCESS cycles already seen; this cycle would be
    // number TIMEOUT. A ready in the same cycle takes priority (w_done).
    assign w_tmo       = (TIMEOUT != 0) && w_in_access && !w_sel_ready &&
                         (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_acc       = req_valid && req_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DERR: begin
                if (!w_acc)         w_next = IDLE;
                else if (w_dec_hit) w_next = SETUP;
                else                w_next = DERR;
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (w_done) begin
                    if (!w_acc)         w_next = IDLE;
                    else if (w_dec_hit) w_next = SETUP;
                    else                w_next = DERR;
                end else if (w_tmo) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from the state register only, so an async reset drops psel and
    // penable immediately.
    always_comb begin
        req_ready = 1'b0;
        w_sel_act = 1'b0;
        penable   = 1'b0;
        case (r_state)
            IDLE, DERR: req_ready = 1'b1;
            SETUP:      w_sel_act = 1'b1;
            ACCESS: begin
                w_sel_act = 1'b1;
                penable   = 1'b1;
                req_ready = w_sel_ready;
            end
            default: ;
        endcase
    end

    generate
        for (genvar g = 0; g < NSLV; g++) begin : g_psel
            assign psel[g] = w_sel_act && (r_idx == SEL_W'(g));
        end
    endgenerate

    // ---------------- request latch ----------------
    // Updated only on an accepted, decodable request, so the APB payload is
    // stable through SETUP/ACCESS and holds its last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
            r_idx <= '0;
        end else if (w_acc && w_dec_hit) begin
            r_req.wr    <= req_wr;
            r_req.addr  <= req_addr;
            r_req.wdata <= req_wdata;
            r_req.strb  <= req_wr ? req_strb : '0;
            r_idx       <= w_dec_idx;
        end
    end

    // ---------------- wait-state counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_cnt <= '0;
        else if (w_in_access && !w_sel_ready) r_cnt <= r_cnt + 1'b1;
        else                                 r_cnt <= '0;
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_rsp_valid <= w_done || w_tmo || (r_state == DERR);
            r_rsp.err   <= w_done ? w_sel_err : (w_tmo || (r_state == DERR));
            r_rsp.rdata <= (w_done && !r_req.wr && !w_sel_err) ? w_sel_rdata : '0;
        end
    end

    assign paddr     = r_req.addr;
    assign pwrite    = r_req.wr;
    assign pwdata    = r_req.wdata;
    assign pstrb     = r_req.strb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;

endmodule
